gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_sync.sv | 17 +
 rtl/gpio_port.sv | 52 +++++
 tb/tb_gpio_port.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and synchroniser depth limits shared by the GPIO block
package gpio_pkg;
  typedef enum logic [1:0] {
    ADDR_PORT     = 2'd0,
    ADDR_DIR      = 2'd1,
    ADDR_IOC_EN   = 2'd2,
    ADDR_IOC_FLAG = 2'd3
  } gpio_addr_e;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: reset-cleared multi-flop synchroniser for the pin inputs
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] sync_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  // shift the raw pin sample one stage deeper on every edge
  always_ff @(posedge clock)
    if (!reset_n) stage_q <= '0;
    else stage_q <= {stage_q[SYNC_STAGES-2:0], pins_i};
  assign sync_o = stage_q[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_port.sv
// gpio_port: register-mapped bidirectional GPIO port with interrupt-on-change
module gpio_port import gpio_pkg::*; #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       addr,
  input  logic             write_en,
  input  logic             out_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  inout  wire  [WIDTH-1:0] dataport,
  output logic             irq,
  output logic [WIDTH-1:0] pins_sync
);
  logic [WIDTH-1:0] port_q, port_d, dir_q, dir_d, ioc_en_q, ioc_en_d, flag_q, flag_d, prev_q, rd_data;
  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .pins_i (dataport),
    .sync_o (pins_sync)
  );
  // register writes; a detected change sets its flag even when the same bit is being cleared
  always_comb begin
    port_d   = write_en && addr == ADDR_PORT   ? data_in : port_q;
    dir_d    = write_en && addr == ADDR_DIR    ? data_in : dir_q;
    ioc_en_d = write_en && addr == ADDR_IOC_EN ? data_in : ioc_en_q;
    flag_d   = (flag_q & ~(write_en && addr == ADDR_IOC_FLAG ? data_in : '0)) | (ioc_en_q & (pins_sync ^ prev_q));
  end
  // state update; reset wins over any write in the same cycle
  always_ff @(posedge clock)
    if (!reset_n) begin
      port_q   <= '0;
      dir_q    <= '0;
      ioc_en_q <= '0;
      flag_q   <= '0;
      prev_q   <= '0;
    end else begin
      port_q   <= port_d;
      dir_q    <= dir_d;
      ioc_en_q <= ioc_en_d;
      flag_q   <= flag_d;
      prev_q   <= pins_sync;
    end
  assign rd_data  = addr == ADDR_PORT ? pins_sync : addr == ADDR_DIR ? dir_q : addr == ADDR_IOC_EN ? ioc_en_q : flag_q;
  assign data_out = out_en ? rd_data : 'z;
  assign irq      = |(flag_q & ioc_en_q);
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign dataport[i] = dir_q[i] ? port_q[i] : 1'bz;
  end
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed and randomized checks of gpio_port against a queue-based reference model
module tb_gpio_port;
  localparam int W = 8;
  localparam int S = 2;
  logic clock = 1'b0, reset_n = 1'b0, write_en = 1'b0, out_en = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [W-1:0] data_in = '0, pin_oe = '0, pin_val = '0, r;
  wire  [W-1:0] data_out, dataport, pins_sync;
  wire irq;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_port = '0, m_dir = '0, m_en = '0, m_flag = '0;
  logic [W-1:0] hist [0:S];

  gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addr     (addr),
    .write_en (write_en),
    .out_en   (out_en),
    .data_in  (data_in),
    .data_out (data_out),
    .dataport (dataport),
    .irq      (irq),
    .pins_sync(pins_sync)
  );

  for (genvar i = 0; i < W; i++) begin : g_pin
    pullup (dataport[i]);
    assign dataport[i] = pin_oe[i] ? pin_val[i] : 1'bz;
  end

  always #5 clock = ~clock;

  // resolved pin levels: driven outputs, bench-driven inputs, otherwise pulled high
  function automatic logic [W-1:0] m_pins();
    return (m_dir & m_port) | (~m_dir & ((pin_oe & pin_val) | ~pin_oe));
  endfunction

  function automatic logic [W-1:0] m_read(input logic [1:0] a);
    return a == 2'd0 ? hist[S-1] : a == 2'd1 ? m_dir : a == 2'd2 ? m_en : m_flag;
  endfunction

  // one clock edge: sample pins before the edge, then apply the register rules to the model
  task automatic tick();
    logic [W-1:0] smp;
    smp = m_pins();
    @(posedge clock);
    if (!reset_n) begin
      m_port = '0; m_dir = '0; m_en = '0; m_flag = '0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
    end else begin
      m_flag = (m_flag & ~((write_en && addr == 2'd3) ? data_in : '0)) | (m_en & (hist[S-1] ^ hist[S]));
      if (write_en && addr == 2'd0) m_port = data_in;
      if (write_en && addr == 2'd1) m_dir = data_in;
      if (write_en && addr == 2'd2) m_en = data_in;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = smp;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    write_en = 1'b1; addr = a; data_in = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++; if (dataport !== 8'hFF) begin n_bad++; $display("FAIL reset_pins: got %h want ff (all released)", dataport); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (pins_sync !== 8'h00) begin n_bad++; $display("FAIL reset_sync: got %h want 00", pins_sync); end
    out_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_read%0d: got %h want 00", a, data_out); end
    end
    out_en = 1'b0;
    reset_n = 1'b1;
    tick(); tick(); tick();
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL post_reset_flag: got %h want 00", data_out); end
    n_cmp++; if (pins_sync !== 8'hFF) begin n_bad++; $display("FAIL post_reset_sync: got %h want ff", pins_sync); end
    out_en = 1'b0;
  endtask

  task automatic test_output_path();
    r = W'($urandom);
    pin_oe = 8'hF0; pin_val = {r[7:4], 4'h0};
    wr(2'd1, 8'h0F);
    write_en = 1'b1; addr = 2'd0; data_in = 8'hA5;
    tick();
    n_cmp++; if (dataport !== {r[7:4], 4'h5}) begin n_bad++; $display("FAIL port_write_edge: got %h want %h", dataport, {r[7:4], 4'h5}); end
    write_en = 1'b0;
    tick();
    out_en = 1'b1; addr = 2'd0; #1;
    n_cmp++; if (data_out === {r[7:4], 4'h5} && r[3:0] != 4'h5) begin n_bad++; $display("FAIL port_read_early: got %h want pre-write value", data_out); end
    tick();
    n_cmp++; if (data_out !== {r[7:4], 4'h5}) begin n_bad++; $display("FAIL port_readback: got %h want %h", data_out, {r[7:4], 4'h5}); end
    out_en = 1'b0;
    pin_oe = '0;
    wr(2'd1, 8'hFF);
    n_cmp++; if (dataport !== 8'hA5) begin n_bad++; $display("FAIL latch_on_dir_set: got %h want a5", dataport); end
  endtask

  task automatic test_ioc();
    wr(2'd1, 8'h00);
    pin_oe = 8'hFF; pin_val = 8'h00;
    tick(); tick(); tick();
    wr(2'd2, 8'h80);
    pin_val = 8'h80;
    tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ioc_irq_early: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ioc_irq_edge3: got %b want 1", irq); end
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h80) begin n_bad++; $display("FAIL ioc_flag: got %h want 80", data_out); end
    out_en = 1'b0;
    wr(2'd3, 8'h80);
    pin_val = 8'hC0;
    tick(); tick(); tick(); tick();
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL ioc_masked_pin6: got %h want 00", data_out); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ioc_masked_irq: got %b want 0", irq); end
    out_en = 1'b0;
  endtask

  task automatic test_w1c_race();
    wr(2'd2, 8'h81);
    pin_val = pin_val ^ 8'h81;
    tick(); tick(); tick();
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h81) begin n_bad++; $display("FAIL w1c_setup: got %h want 81", data_out); end
    out_en = 1'b0;
    wr(2'd3, 8'h01);
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h80) begin n_bad++; $display("FAIL w1c_clear: got %h want 80", data_out); end
    out_en = 1'b0;
    pin_val = pin_val ^ 8'h01;
    tick(); tick(); tick();
    pin_val = pin_val ^ 8'h01;
    tick(); tick();
    write_en = 1'b1; addr = 2'd3; data_in = 8'h01; out_en = 1'b1; #1;
    n_cmp++; if (data_out !== 8'h81) begin n_bad++; $display("FAIL w1c_same_cycle_read: got %h want 81", data_out); end
    tick();
    write_en = 1'b0; #1;
    n_cmp++; if (data_out !== 8'h81) begin n_bad++; $display("FAIL w1c_race_set_wins: got %h want 81", data_out); end
    out_en = 1'b0;
    wr(2'd3, 8'h01);
    out_en = 1'b1; #1;
    n_cmp++; if (data_out !== 8'h80) begin n_bad++; $display("FAIL w1c_clear2: got %h want 80", data_out); end
    out_en = 1'b0;
  endtask

  task automatic test_mask();
    wr(2'd2, 8'h00);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mask_irq: got %b want 0", irq); end
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h80) begin n_bad++; $display("FAIL mask_flag_kept: got %h want 80", data_out); end
    out_en = 1'b0;
    wr(2'd2, 8'h80);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL unmask_irq: got %b want 1", irq); end
  endtask

  task automatic test_mid_reset();
    pin_oe = '0;
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h3C);
    n_cmp++; if (dataport !== 8'h3C) begin n_bad++; $display("FAIL pre_reset_pins: got %h want 3c", dataport); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    reset_n = 1'b0; write_en = 1'b1; addr = 2'd1; data_in = 8'hFF;
    tick();
    write_en = 1'b0;
    n_cmp++; if (dataport !== 8'hFF) begin n_bad++; $display("FAIL mid_reset_pins: got %h want ff (released)", dataport); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
    out_en = 1'b1; addr = 2'd3; #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL mid_reset_flag: got %h want 00", data_out); end
    addr = 2'd1; #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL mid_reset_dir: got %h want 00", data_out); end
    out_en = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset_n  = $urandom_range(63) != 0;
      write_en = 1'($urandom_range(1));
      addr     = 2'($urandom_range(3));
      data_in  = W'($urandom);
      out_en   = 1'($urandom_range(1));
      pin_oe   = W'($urandom) & ~m_dir;
      pin_val  = pin_val ^ (W'($urandom) & W'($urandom));
      #1;
      n_cmp++; if (dataport !== m_pins()) begin n_bad++; $display("FAIL rnd_pins[%0d]: got %h want %h", k, dataport, m_pins()); end
      n_cmp++; if (pins_sync !== hist[S-1]) begin n_bad++; $display("FAIL rnd_sync[%0d]: got %h want %h", k, pins_sync, hist[S-1]); end
      n_cmp++; if (irq !== |(m_flag & m_en)) begin n_bad++; $display("FAIL rnd_irq[%0d]: got %b want %b", k, irq, |(m_flag & m_en)); end
      if (out_en) begin
        n_cmp++; if (data_out !== m_read(addr)) begin n_bad++; $display("FAIL rnd_read[%0d] a=%0d: got %h want %h", k, addr, data_out, m_read(addr)); end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i <= S; i++) hist[i] = '0;
    test_reset();
    test_output_path();
    test_ioc();
    test_w1c_race();
    test_mask();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
